// File: rtl/cam_array.sv
// rtl/cam_array.sv - content-addressable key array with registered match vector and sequential flush
// Searches compare against pre-write contents; flush clears one valid bit per cycle.
module cam_array #(
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = 1 << ADDR_WIDTH,
  parameter int KEY_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_enable,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [KEY_WIDTH-1:0]  wr_data,
  input  logic                  wr_valid,
  input  logic                  search_enable,
  input  logic [KEY_WIDTH-1:0]  search_key,
  input  logic                  flush_req,
  output logic [DEPTH-1:0]      match_out,
  output logic                  match_valid,
  output logic                  busy
);

  typedef enum logic {S_IDLE = 1'b0, S_FLUSH = 1'b1} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [KEY_WIDTH-1:0]  key_q [DEPTH];
  logic [KEY_WIDTH-1:0]  key_d [DEPTH];
  logic [DEPTH-1:0]      valid_q, valid_d;
  logic [DEPTH-1:0]      match_q, match_d;
  logic                  match_valid_q, match_valid_d;

  logic idle, wr_accept, search_accept, flush_start, flush_last;

  assign idle          = (state_q == S_IDLE);
  assign wr_accept     = idle & wr_enable & ~flush_req;
  assign search_accept = idle & search_enable;
  assign flush_start   = idle & flush_req;
  assign flush_last    = (cnt_q == ADDR_WIDTH'(DEPTH - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (flush_req) state_d = S_FLUSH;
      S_FLUSH: if (flush_last) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == S_FLUSH);
  end

  // Match uses key_q/valid_q, so a same-cycle write is only visible next cycle.
  always_comb begin
    cnt_d         = cnt_q;
    valid_d       = valid_q;
    key_d         = key_q;
    match_d       = '0;
    match_valid_d = search_accept;
    if (flush_start) begin
      cnt_d = '0;
    end else if (!idle) begin
      valid_d[cnt_q] = 1'b0;
      cnt_d          = cnt_q + 1'b1;
    end
    if (wr_accept) begin
      key_d[wr_addr]   = wr_data;
      valid_d[wr_addr] = wr_valid;
    end
    for (int i = 0; i < DEPTH; i++) begin
      match_d[i] = search_accept & valid_q[i] & (key_q[i] == search_key);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q         <= '0;
      valid_q       <= '0;
      match_q       <= '0;
      match_valid_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) key_q[i] <= '0;
    end else begin
      cnt_q         <= cnt_d;
      valid_q       <= valid_d;
      match_q       <= match_d;
      match_valid_q <= match_valid_d;
      for (int i = 0; i < DEPTH; i++) key_q[i] <= key_d[i];
    end
  end

  assign match_out   = match_q;
  assign match_valid = match_valid_q;

endmodule

// File: tb/tb_cam_array.sv
// tb/tb_cam_array.sv - directed and randomized self-checking bench for cam_array
// Reference keeps keys/valids in arrays; a flush is modelled as an instant clear plus a busy countdown.
module tb_cam_array;

  localparam int AW = 4;
  localparam int D  = 16;
  localparam int KW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_enable;
  logic [AW-1:0] wr_addr;
  logic [KW-1:0] wr_data;
  logic          wr_valid;
  logic          search_enable;
  logic [KW-1:0] search_key;
  logic          flush_req;
  logic [D-1:0]  match_out;
  logic          match_valid;
  logic          busy;

  int checks   = 0;
  int failures = 0;

  logic [KW-1:0] m_key   [D];
  logic          m_valid [D];
  int            flush_left;

  cam_array #(.ADDR_WIDTH(AW), .DEPTH(D), .KEY_WIDTH(KW)) dut (
    .clk(clk), .reset(reset),
    .wr_enable(wr_enable), .wr_addr(wr_addr), .wr_data(wr_data), .wr_valid(wr_valid),
    .search_enable(search_enable), .search_key(search_key), .flush_req(flush_req),
    .match_out(match_out), .match_valid(match_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [D-1:0] obs, input logic [D-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < D; i++) begin
      m_key[i]   = '0;
      m_valid[i] = 1'b0;
    end
    flush_left = 0;
  endtask

  // Called at posedge+1; drives one cycle of inputs and checks outputs after the next edge.
  task automatic cycle(input logic we, input logic [AW-1:0] wa, input logic [KW-1:0] wd,
                       input logic wv, input logic se, input logic [KW-1:0] sk,
                       input logic fr, input string tag);
    logic [D-1:0] exp_match;
    logic         exp_mv;
    wr_enable = we; wr_addr = wa; wr_data = wd; wr_valid = wv;
    search_enable = se; search_key = sk; flush_req = fr;
    exp_match = '0;
    exp_mv    = 1'b0;
    if (flush_left == 0) begin
      if (se) begin
        exp_mv = 1'b1;
        for (int i = 0; i < D; i++)
          if (m_valid[i] && m_key[i] == sk) exp_match[i] = 1'b1;
      end
      if (fr) begin
        flush_left = D;
        for (int i = 0; i < D; i++) m_valid[i] = 1'b0;
      end else if (we) begin
        m_key[wa]   = wd;
        m_valid[wa] = wv;
      end
    end else begin
      flush_left--;
    end
    @(posedge clk);
    #1;
    check({tag, ".match_out"}, match_out, exp_match);
    check({tag, ".match_valid"}, {15'b0, match_valid}, {15'b0, exp_mv});
    check({tag, ".busy"}, {15'b0, busy}, {15'b0, (flush_left > 0)});
  endtask

  task automatic idle_cycle(input string tag);
    cycle(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0, tag);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [KW-1:0] k, input logic v, input string tag);
    cycle(1'b1, a, k, v, 1'b0, '0, 1'b0, tag);
  endtask

  task automatic srch(input logic [KW-1:0] k, input string tag);
    cycle(1'b0, '0, '0, 1'b0, 1'b1, k, 1'b0, tag);
  endtask

  task automatic do_reset(input string tag);
    #2 reset = 1'b1;
    #1;
    check({tag, ".busy"}, {15'b0, busy}, '0);
    check({tag, ".match_valid"}, {15'b0, match_valid}, '0);
    check({tag, ".match_out"}, match_out, '0);
    model_clear();
    @(posedge clk);
    #2 reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    wr_enable = 0; wr_addr = '0; wr_data = '0; wr_valid = 0;
    search_enable = 0; search_key = '0; flush_req = 0;
    model_clear();
    @(posedge clk);
    #1;
    check("reset.match_out", match_out, '0);
    check("reset.match_valid", {15'b0, match_valid}, '0);
    check("reset.busy", {15'b0, busy}, '0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    srch(8'h00, "post_reset_miss");
    check("post_reset_miss.spec", match_out, 16'h0000);

    wr(4'd3, 8'hA5, 1'b1, "w3");
    srch(8'hA5, "s_a5");
    check("s_a5.spec", match_out, 16'h0008);

    wr(4'd2, 8'h3C, 1'b1, "w2");
    wr(4'd9, 8'h3C, 1'b1, "w9");
    srch(8'h3C, "s_3c_dup");
    check("s_3c_dup.spec", match_out, 16'h0204);
    wr(4'd2, 8'h3C, 1'b0, "inv2");
    srch(8'h3C, "s_3c_single");
    check("s_3c_single.spec", match_out, 16'h0200);

    do_reset("rst_a");
    cycle(1'b1, 4'd5, 8'h11, 1'b1, 1'b1, 8'h11, 1'b0, "same_cycle");
    check("same_cycle.spec", match_out, 16'h0000);
    srch(8'h11, "after_write");
    check("after_write.spec", match_out, 16'h0020);

    for (int i = 0; i < D; i++) wr(AW'(i), 8'h7E, 1'b1, "fill");
    srch(8'h7E, "full_hit");
    check("full_hit.spec", match_out, 16'hFFFF);
    cycle(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b1, "flush_go");
    for (int i = 0; i < D - 1; i++) srch(8'h7E, "flush_busy_search");
    srch(8'h7E, "flush_done_search");
    check("flush_done.spec", match_out, 16'h0000);

    for (int i = 0; i < 4; i++) wr(AW'(i), 8'h44, 1'b1, "fill2");
    cycle(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b1, "flush2_go");
    for (int i = 0; i < 4; i++) idle_cycle("flush2_mid");
    do_reset("rst_mid_flush");
    srch(8'h44, "after_rst_flush");
    check("after_rst_flush.spec", match_out, 16'h0000);

    cycle(1'b1, 4'd0, 8'h01, 1'b1, 1'b0, '0, 1'b1, "flush_vs_write");
    for (int i = 0; i < D; i++) idle_cycle("flush3");
    srch(8'h01, "dropped_write");
    check("dropped_write.spec", match_out, 16'h0000);

    for (int n = 0; n < 400; n++) begin
      cycle(1'($urandom_range(0, 1)), AW'($urandom_range(0, D - 1)),
            KW'($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 1)), KW'($urandom_range(0, 3)),
            1'($urandom_range(0, 39) == 0), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
